// File: rtl/uart_pkg.sv
// Shared types for the queued UART transmitter: line configuration struct,
// transmitter state encoding and the data-length clamp helper.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam logic [3:0] DATA_LEN_MIN = 4'd5;

  typedef struct packed {
    logic       parity_en;
    logic       parity_odd;
    logic [3:0] data_len;
    logic       stop2;
  } uart_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
`ifdef UART_TX_BREAK_EN
    ST_STOP,
    ST_BREAK
`else
    ST_STOP
`endif
  } txq_state_e;

  // Data length actually used for a frame: never shorter than DATA_LEN_MIN,
  // never wider than the data path.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    if (len < DATA_LEN_MIN) return DATA_LEN_MIN;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/uart_txq_fifo.sv
// Synchronous show-ahead FIFO holding frames waiting for the transmitter.
// Push is ignored while full, pop is ignored while empty; rdata always
// presents the head entry.
module uart_txq_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array carries no reset; validity is tracked by the pointers
  // and level, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_txq.sv
// UART transmitter with built-in TX queue. Runtime data length (5..DATA_MAX),
// parity none/even/odd, 1 or 2 stop bits and bit period; frames leave the
// queue back to back with no idle gap. Line configuration is captured when a
// frame starts, so changes mid-frame apply to the next frame.
// Optional feature macro: UART_TX_BREAK_EN adds break_req and the BREAK state.
module uart_txq
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CPB_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  uart_cfg_t              cfg,
  input  logic [CPB_W-1:0]       clks_per_bit,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_MAX-1:0]    s_data,
  output logic                   txd,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                   break_req
`endif
);

  localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);

  txq_state_e          state_q, state_d;
  logic [CPB_W-1:0]    timer_q, timer_d;
  logic [CPB_W-1:0]    cpb_q, cpb_d, cpb_eff;
  logic [DATA_MAX-1:0] shift_q, shift_d, head;
  logic [3:0]          len_q, len_d, len_eff;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d, par_calc;
  logic                stop2_q, stop2_d;
  logic                bit_end, load, pop;
  logic                fifo_full, fifo_empty;
`ifdef UART_TX_BREAK_EN
  logic                mark_q, mark_d, start_break;
`endif

  uart_txq_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign s_ready = !fifo_full;
  assign tx_busy = (state_q != ST_IDLE);
  assign cpb_eff = (clks_per_bit < CPB_W'(2)) ? CPB_W'(2) : clks_per_bit;
  assign len_eff = clamp_len(cfg.data_len, LEN_MAX);
  assign bit_end = (timer_q == cpb_q - CPB_W'(1));

  // Parity of the head entry over the bits that will actually be sent.
  always_comb begin
    par_calc = cfg.parity_odd;
    for (int i = 0; i < int'(DATA_MAX); i++) begin
      if (i < int'(len_eff)) par_calc = par_calc ^ head[i];
    end
  end

  // Next-state, datapath update and line outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    timer_d   = (state_q == ST_IDLE || bit_end) ? '0 : timer_q + CPB_W'(1);
    cpb_d     = cpb_q;
    shift_d   = shift_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    load      = 1'b0;
    pop       = 1'b0;
    txd       = 1'b1;
    tx_done   = 1'b0;
`ifdef UART_TX_BREAK_EN
    mark_d      = mark_q;
    start_break = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) start_break = 1'b1;
        else
`endif
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        txd = 1'b0;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        txd = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == len_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        txd = par_bit_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == {3'b000, stop2_q}) begin
            tx_done = 1'b1;
`ifdef UART_TX_BREAK_EN
            if (break_req) start_break = 1'b1;
            else
`endif
            if (!fifo_empty) load = 1'b1;
            else state_d = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!mark_q) begin
          // Low phase: timer saturates once one bit time has elapsed and
          // the line is held until the request drops.
          txd = 1'b0;
          if (bit_end) begin
            if (break_req) timer_d = timer_q;
            else mark_d = 1'b1;
          end
        end else if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      state_d   = ST_START;
      timer_d   = '0;
      cpb_d     = cpb_eff;
      shift_d   = head;
      len_d     = len_eff;
      bit_cnt_d = '0;
      par_en_d  = cfg.parity_en;
      par_bit_d = par_calc;
      stop2_d   = cfg.stop2;
    end
`ifdef UART_TX_BREAK_EN
    if (start_break) begin
      state_d = ST_BREAK;
      timer_d = '0;
      cpb_d   = cpb_eff;
      mark_d  = 1'b0;
    end
`endif
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      cpb_q     <= CPB_W'(2);
      shift_q   <= '0;
      len_q     <= DATA_LEN_MIN;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      mark_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cpb_q     <= cpb_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
`ifdef UART_TX_BREAK_EN
      mark_q    <= mark_d;
`endif
    end
  end

endmodule
